// File: rtl/width_conv_fifo.sv
`default_nettype none
// ============================================================================
// Module      : width_conv_fifo
// Description : Circular FIFO that accepts RATIO*OUT_W-bit beats and returns
//               OUT_W-bit words one at a time. It supports concurrent read and
//               write, reports occupancy and almost-full, selects lane order
//               and clears synchronously on flush. The head word falls
//               through to the output.
// Revision    : 1.0 - initial release
// ============================================================================
module width_conv_fifo #(
    parameter int OUT_W     = 8,
    parameter int RATIO     = 2,
    parameter int DEPTH     = 32,
    parameter int AF_THRESH = 24,
    parameter int MSB_FIRST = 0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OUT_W*RATIO-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;

    // Pointer step per beat and level limits, sized to their destinations
    localparam logic [c_AW-1:0] c_WR_STEP   = c_AW'(RATIO);
    localparam logic [c_LW-1:0] c_LVL_WR    = c_LW'(RATIO);
    localparam logic [c_LW-1:0] c_LVL_BOTH  = c_LW'(RATIO - 1);
    localparam logic [c_LW-1:0] c_LVL_SPACE = c_LW'(DEPTH - RATIO);
    localparam logic [c_LW-1:0] c_LVL_AF    = c_LW'(AF_THRESH);

    logic [OUT_W-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_LW-1:0]  r_level;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_wr_fire;
    logic             w_rd_fire;
    logic [c_AW-1:0]  w_lane_addr [RATIO];

    // Handshake status depends only on the registered level, so there is
    // no combinational path from out_ready back to in_ready.
    assign w_in_ready  = (r_level <= c_LVL_SPACE);
    assign w_out_valid = (r_level != '0);
    assign w_wr_fire   = in_valid && w_in_ready;
    assign w_rd_fire   = w_out_valid && out_ready;

    assign in_ready    = w_in_ready;
    assign out_valid   = w_out_valid;
    assign out_data    = w_out_valid ? r_mem[r_rd_ptr] : '0;
    assign level       = r_level;
    assign almost_full = (r_level >= c_LVL_AF);

    // Destination address of each input lane; the pointer width makes the
    // addition wrap modulo DEPTH.
    for (genvar k = 0; k < RATIO; k++) begin : g_lane
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_lane_addr[k] = r_wr_ptr + c_AW'(RATIO - 1 - k);
        end else begin : g_lsb_first
            assign w_lane_addr[k] = r_wr_ptr + c_AW'(k);
        end
    end

    // Storage write: every lane of an accepted beat lands in one cycle;
    // a flush in the same cycle discards the beat.
    always_ff @(posedge clk) begin
        if (w_wr_fire && !flush) begin
            for (int k = 0; k < RATIO; k++) begin
                r_mem[w_lane_addr[k]] <= in_data[k*OUT_W +: OUT_W];
            end
        end
    end

    // Pointer and occupancy bookkeeping; flush overrides any handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + c_WR_STEP;
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_fire, w_rd_fire})
                2'b10:   r_level <= r_level + c_LVL_WR;
                2'b01:   r_level <= r_level - 1'b1;
                2'b11:   r_level <= r_level + c_LVL_BOTH;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_width_conv_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_width_conv_fifo
// Description : Self-checking bench for width_conv_fifo. It drives the default
//               configuration against a byte-queue model and uses two
//               MSB-first instances to check lane order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_width_conv_fifo;

    logic clk = 1'b0;
    logic rstn;

    // Default configuration instance
    logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0, af0;
    logic [15:0] in_data0;
    logic [7:0]  out_data0;
    logic [5:0]  level0;

    // MSB_FIRST=1, RATIO=2 instance
    logic        flush1, in_valid1, in_ready1, out_valid1, out_ready1, af1;
    logic [15:0] in_data1;
    logic [7:0]  out_data1;
    logic [5:0]  level1;

    // MSB_FIRST=1, RATIO=4 instance
    logic        flush2, in_valid2, in_ready2, out_valid2, out_ready2, af2;
    logic [31:0] in_data2;
    logic [7:0]  out_data2;
    logic [5:0]  level2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the words currently held, head first
    logic [7:0] r_model_q [$];

    always #5 clk = ~clk;

    width_conv_fifo #(.OUT_W(8), .RATIO(2), .DEPTH(32), .AF_THRESH(24), .MSB_FIRST(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .flush(flush0), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_data(in_data0), .out_valid(out_valid0), .out_ready(out_ready0),
        .out_data(out_data0), .level(level0), .almost_full(af0));

    width_conv_fifo #(.OUT_W(8), .RATIO(2), .DEPTH(32), .AF_THRESH(24), .MSB_FIRST(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1), .level(level1), .almost_full(af1));

    width_conv_fifo #(.OUT_W(8), .RATIO(4), .DEPTH(32), .AF_THRESH(24), .MSB_FIRST(1)) u_dut2 (
        .clk(clk), .rstn(rstn), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .level(level2), .almost_full(af2));

    // Count one comparison and report it on mismatch
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every output of instance 0 with the model
    task automatic check_outputs0(input string tag);
        int sz;
        sz = r_model_q.size();
        check({tag, "_level"}, 32'(level0), 32'(sz));
        check({tag, "_in_ready"}, 32'(in_ready0), 32'(sz <= 30));
        check({tag, "_out_valid"}, 32'(out_valid0), 32'(sz != 0));
        check({tag, "_out_data"}, 32'(out_data0), (sz != 0) ? 32'(r_model_q[0]) : 32'h0);
        check({tag, "_almost_full"}, 32'(af0), 32'(sz >= 24));
    endtask

    // One clock on instance 0: drive inputs, check outputs, update the model
    task automatic cycle0(input logic iv, input logic [15:0] d, input logic ordy, input logic fl);
        logic wr, rd;
        in_valid0  = iv;
        in_data0   = d;
        out_ready0 = ordy;
        flush0     = fl;
        #1;
        check_outputs0("cyc");
        wr = iv && (r_model_q.size() <= 30);
        rd = ordy && (r_model_q.size() != 0);
        @(posedge clk);
        #1;
        if (fl) begin
            r_model_q.delete();
        end else begin
            if (rd) void'(r_model_q.pop_front());
            if (wr) begin
                r_model_q.push_back(d[7:0]);
                r_model_q.push_back(d[15:8]);
            end
        end
    endtask

    // Read instance 0 until the model is empty, within a cycle budget
    task automatic drain0();
        int budget;
        budget = 0;
        while (r_model_q.size() != 0 && budget < 200) begin
            cycle0(1'b0, 16'h0, 1'b1, 1'b0);
            budget++;
        end
        check("drain_done", 32'(r_model_q.size()), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int beats;
        int cyc;
        logic iv, ordy;
        logic [15:0] d;

        rstn = 1'b0;
        {flush0, in_valid0, out_ready0, flush1, in_valid1, out_ready1} = '0;
        {flush2, in_valid2, out_ready2} = '0;
        in_data0 = '0;
        in_data1 = '0;
        in_data2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        check_outputs0("por");

        // Asynchronous reset while holding ten words
        for (int i = 0; i < 5; i++) cycle0(1'b1, 16'(i * 16'h0202 + 16'h0100), 1'b0, 1'b0);
        check("pre_rst_level", 32'(level0), 32'd10);
        in_valid0 = 1'b0;
        rstn      = 1'b0;
        #1;
        r_model_q.delete();
        check("rst_level", 32'(level0), 32'h0);
        check("rst_in_ready", 32'(in_ready0), 32'h1);
        check("rst_out_valid", 32'(out_valid0), 32'h0);
        check("rst_out_data", 32'(out_data0), 32'h0);
        check("rst_af", 32'(af0), 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Fill to full with reads held off; in_ready and almost_full are
        // checked against the model on every cycle
        for (int i = 0; i < 16; i++) begin
            d = {8'(2 * i + 1), 8'(2 * i)};
            cycle0(1'b1, d, 1'b0, 1'b0);
        end
        check("full_level", 32'(level0), 32'd32);
        check("full_in_ready", 32'(in_ready0), 32'h0);
        cycle0(1'b1, 16'hDEAD, 1'b0, 1'b0);
        check("full_no_write", 32'(level0), 32'd32);
        for (int i = 0; i < 32; i++) begin
            #1;
            check("drain_byte", 32'(out_data0), 32'(i));
            cycle0(1'b0, 16'h0, 1'b1, 1'b0);
        end
        check_outputs0("empty");

        // Concurrent read and write at level 5
        cycle0(1'b1, 16'h1110, 1'b0, 1'b0);
        cycle0(1'b1, 16'h1312, 1'b0, 1'b0);
        cycle0(1'b1, 16'h1514, 1'b0, 1'b0);
        cycle0(1'b0, 16'h0, 1'b1, 1'b0);
        check("conc_pre_level", 32'(level0), 32'd5);
        check("conc_pre_head", 32'(out_data0), 32'h11);
        cycle0(1'b1, 16'h1716, 1'b1, 1'b0);
        check("conc_level", 32'(level0), 32'd6);
        check("conc_head", 32'(out_data0), 32'h12);
        drain0();

        // Random traffic for 200 accepted beats, then empty the FIFO
        beats = 0;
        cyc   = 0;
        while (beats < 200 && cyc < 5000) begin
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            d    = 16'($urandom);
            if (iv && r_model_q.size() <= 30) beats++;
            cycle0(iv, d, ordy, 1'b0);
            cyc++;
        end
        check("rand_beats", 32'(beats), 32'd200);
        drain0();

        // Flush at level 12 with a write and a read in the same cycle
        for (int i = 0; i < 6; i++) cycle0(1'b1, 16'(16'hA0A1 + i), 1'b0, 1'b0);
        check("flush_pre_level", 32'(level0), 32'd12);
        cycle0(1'b1, 16'hEEEE, 1'b1, 1'b1);
        check("flush_level", 32'(level0), 32'h0);
        check("flush_out_valid", 32'(out_valid0), 32'h0);
        check("flush_in_ready", 32'(in_ready0), 32'h1);
        cycle0(1'b1, 16'h5A5B, 1'b0, 1'b0);
        check("post_flush_head", 32'(out_data0), 32'h5B);
        drain0();

        // Top lane first, RATIO=2 and RATIO=4
        in_valid1 = 1'b1;
        in_data1  = 16'hABCD;
        in_valid2 = 1'b1;
        in_data2  = 32'h11223344;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        check("msb2_level", 32'(level1), 32'd2);
        check("msb4_level", 32'(level2), 32'd4);
        out_ready1 = 1'b1;
        out_ready2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp4;
            logic [15:0] exp2;
            exp4 = 32'h11223344;
            exp2 = 16'hABCD;
            if (i < 2) check("msb2_word", 32'(out_data1), 32'(exp2[15 - 8*i -: 8]));
            check("msb4_word", 32'(out_data2), 32'(exp4[31 - 8*i -: 8]));
            @(posedge clk);
            #1;
        end
        check("msb2_empty", 32'(out_valid1), 32'h0);
        check("msb4_empty", 32'(out_valid2), 32'h0);
        out_ready1 = 1'b0;
        out_ready2 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
